// File: rtl/imm_decode_pipe_if.sv
// rtl/imm_decode_pipe_if.sv - instruction-in / decoded-out handshake bundle
interface imm_decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode_pipe.sv
// rtl/imm_decode_pipe.sv - RISC-V immediate/target decoder behind a main+skid register pair
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_decode_pipe_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_pipe: XLEN must be 32 or 64");
    end

    localparam int SW = (XLEN == 64) ? 6 : 5;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_SH   = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [31:0]        w_i;
    logic [2:0]         w_f3;
    logic               w_shift_f3;
    logic signed [31:0] w_u32;
    logic [XLEN-1:0]    w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0]    w_imm_sh, w_imm_sh5, w_imm_z;
    logic [XLEN-1:0]    w_imm;
    logic [2:0]         w_fmt;
    logic               w_illegal;
    logic               w_pc_rel;
    entry_t             w_new;

    assign w_i        = bus.in_instr;
    assign w_f3       = w_i[14:12];
    assign w_shift_f3 = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_u32      = {w_i[31:12], 12'h000};

    assign w_imm_i   = {{(XLEN-12){w_i[31]}}, w_i[31:20]};
    assign w_imm_s   = {{(XLEN-12){w_i[31]}}, w_i[31:25], w_i[11:7]};
    assign w_imm_b   = {{(XLEN-13){w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
    assign w_imm_j   = {{(XLEN-21){w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
    assign w_imm_u   = XLEN'(w_u32);
    assign w_imm_sh  = XLEN'(w_i[20 +: SW]);
    assign w_imm_sh5 = XLEN'(w_i[24:20]);
    assign w_imm_z   = XLEN'(w_i[19:15]);

    always_comb begin
        w_fmt     = FMT_NONE;
        w_imm     = '0;
        w_illegal = 1'b0;
        w_pc_rel  = 1'b0;
        case (w_i[6:0])
            7'b0110011: w_fmt = FMT_NONE;
            7'b0010011: begin
                w_fmt = w_shift_f3 ? FMT_SH : FMT_I;
                w_imm = w_shift_f3 ? w_imm_sh : w_imm_i;
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
                w_fmt = FMT_I;
                w_imm = w_imm_i;
            end
            7'b0100011: begin w_fmt = FMT_S; w_imm = w_imm_s; end
            7'b1100011: begin w_fmt = FMT_B; w_imm = w_imm_b; w_pc_rel = 1'b1; end
            7'b0110111: begin w_fmt = FMT_U; w_imm = w_imm_u; end
            7'b0010111: begin w_fmt = FMT_U; w_imm = w_imm_u; w_pc_rel = 1'b1; end
            7'b1101111: begin w_fmt = FMT_J; w_imm = w_imm_j; w_pc_rel = 1'b1; end
            7'b1110011: begin
                w_fmt = w_f3[2] ? FMT_Z : FMT_I;
                w_imm = w_f3[2] ? w_imm_z : w_imm_i;
            end
            7'b0111011: w_illegal = (XLEN != 64);
            7'b0011011: begin
                // word-sized shifts keep a 5-bit shamt even on RV64
                w_illegal = (XLEN != 64);
                if (XLEN == 64) begin
                    w_fmt = w_shift_f3 ? FMT_SH : FMT_I;
                    w_imm = w_shift_f3 ? w_imm_sh5 : w_imm_i;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_new.instr   = w_i;
    assign w_new.pc      = bus.in_pc;
    assign w_new.imm     = w_imm;
    assign w_new.target  = w_pc_rel ? (bus.in_pc + w_imm) : '0;
    assign w_new.fmt     = w_fmt;
    assign w_new.illegal = w_illegal;

    entry_t           r_m, r_k;
    logic             r_m_valid, r_k_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire, w_m_free;

    assign w_in_fire = bus.in_valid && !r_k_valid;
    assign w_m_free  = !r_m_valid || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= '0;
            r_k       <= '0;
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else begin
            if (w_m_free) begin
                // in_ready is low whenever K holds data, so K and a new input never compete
                if (r_k_valid) begin
                    r_m       <= r_k;
                    r_m_valid <= 1'b1;
                    r_k_valid <= 1'b0;
                end else begin
                    r_m_valid <= w_in_fire;
                    if (w_in_fire) r_m <= w_new;
                end
            end else if (w_in_fire) begin
                r_k       <= w_new;
                r_k_valid <= 1'b1;
            end
            if (w_in_fire && w_new.illegal && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = !r_k_valid;
    assign bus.out_valid   = r_m_valid;
    assign bus.out_instr   = r_m.instr;
    assign bus.out_pc      = r_m.pc;
    assign bus.out_imm     = r_m.imm;
    assign bus.out_target  = r_m.target;
    assign bus.out_fmt     = r_m.fmt;
    assign bus.out_illegal = r_m.illegal;
    assign illegal_cnt     = r_cnt;
endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 or 64 legal; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports, in order: clk, input, 1, rising-edge clock; rst, input, 1, async active-high reset.
REQ-005 flush input 1 synchronous pipeline clear; in_valid input 1; in_ready output 1; in_instr input 32; in_pc input XLEN.
REQ-006 out_valid output 1; out_ready input 1; out_instr output 32; out_pc output XLEN; out_imm output XLEN; out_target output XLEN.
REQ-007 out_fmt output 3 (0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z csr-zimm, 7 SH shamt); out_illegal output 1; illegal_cnt output CNT_W.

Function
REQ-008 Input transfer SHALL occur on in_valid&&in_ready at a rising edge; output transfer on out_valid&&out_ready.
REQ-009 Storage SHALL be main register M (drives out_*) plus skid register K; in_ready SHALL equal !K.valid (registered, no combinational path from out_ready).
REQ-010 When M is empty or draining: M loads K if K valid, else the accepted input; K becomes empty.
REQ-011 When M holds and is not draining, an accepted input SHALL load K.
REQ-012 Latency SHALL be 1 cycle (accept at edge N, out_valid after edge N) when M is free; throughput 1/cycle with out_ready high.
REQ-013 Order SHALL be preserved; no loss or duplication; out_* stable while out_valid&&!out_ready.
REQ-014 Decode SHALL be combinational on in_instr, stored with instr and pc.
REQ-015 Sign extension SHALL replicate instr[31] to XLEN: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; J {31,19:12,20,30:21,0}; U {31:12, 12 zeros} sign-extended to XLEN.
REQ-016 Opcode map: 0110011 NONE; 0010011/0000011/1100111/0001111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; 1110011 I, but Z when funct3[2]=1.
REQ-017 XLEN=64 only: 0111011 NONE, 0011011 I; in XLEN=32 both SHALL be illegal.
REQ-018 Shift immediates: opcode 0010011 funct3 001/101 -> SH, imm = zero-extend instr[20+SW-1:20], SW=5 (XLEN 32) or 6 (XLEN 64); 0011011 shifts SW=5.
REQ-019 Z: imm = zero-extend instr[19:15].
REQ-020 NONE: imm = 0.
REQ-021 Illegal (instr[1:0]!=11 or opcode unmapped): out_illegal=1, fmt=0, imm=0, target=0.
REQ-022 out_target SHALL be pc+imm modulo 2^XLEN for B, J and 0010111 (AUIPC); 0 otherwise.
REQ-023 illegal_cnt SHALL increment on each accepted illegal instruction, saturating at all-ones, never wrapping.
REQ-024 flush SHALL clear M.valid and K.valid at the next edge and has priority over all transfers; input presented that cycle is discarded and not counted.
REQ-025 Data fields when out_valid=0 are don't-care except after reset.

Reset
REQ-026 rst assertion SHALL immediately force M.valid=0, K.valid=0, out_valid=0, in_ready=1, illegal_cnt=0, and all out_* data to 0.
REQ-027 After rst deasserts, the first accept SHALL be possible at the next rising edge.

Verification
REQ-028 XLEN=32, 0xFFF00093 (ADDI -1), pc 0x100, out_ready=1 -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt 1, target 0.
REQ-029 0xFE000EE3 (BEQ -4), pc 0x200 -> imm 0xFFFFFFFC, fmt 3, target 0x1FC.
REQ-030 out_ready=0, three back-to-back inputs A,B,C -> A,B accepted, in_ready=0 with C held; out_ready=1 -> A,B,C emitted in order, no gaps once C is accepted.
REQ-031 XLEN=64, 0x03F09093 (SLLI 63) -> imm 63, fmt 7; same in XLEN=32 -> imm 31 (instr[24:20]), fmt 7.
REQ-032 CNT_W=2, four 0x00000000 inputs -> out_illegal=1 each, imm 0, illegal_cnt 1,2,3,3; flush with M,K full -> out_valid=0 next cycle, counter unchanged.
REQ-033 rst asserted mid-stream with M,K full -> out_valid=0 and in_ready=1 without a clock edge, illegal_cnt=0.
